// File: rtl/mole_controller.sv
// rtl/mole_controller.sv - whack-a-mole sequencer: LFSR mole placement, show/gap timing, hit/miss counting.
// Optional MOLE_SPEEDUP_EN: each hit shrinks the visible window by WINDOW_STEP, floored at WINDOW_MIN.
module mole_controller #(
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         WINDOW_INIT = 40,
    parameter int         WINDOW_MIN  = 10,
    parameter int         WINDOW_STEP = 2,
    parameter int         GAP_TICKS   = 5,
    parameter int         ROUNDS      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       guess_correct,
    input  logic       guess_wrong,
    output logic [2:0] mole_pos,
    output logic       mole_change,
    output logic       mole_visible,
    output logic [5:0] round_cnt,
    output logic [5:0] miss_cnt,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE, SHOW, GAP, OVER} state_t;

    localparam logic [7:0] GAP_LD   = 8'(GAP_TICKS);
    localparam logic [5:0] ROUNDS_C = 6'(ROUNDS);

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] show_cnt_q, show_cnt_d;
    logic [2:0] mole_pos_q, mole_pos_d;
    logic       mole_change_q, mole_change_d;
    logic       mole_visible_q, mole_visible_d;
    logic [5:0] round_cnt_q, round_cnt_d;
    logic [5:0] miss_cnt_q, miss_cnt_d;
    logic       game_over_q, game_over_d;
    logic [7:0] window_cur;
    logic [7:0] lfsr_step;
    logic [2:0] pos_raw;
    logic [2:0] pos_next;
    logic       unused_guess_wrong;

    // guess_wrong is informational only; the mole stays up regardless.
    assign unused_guess_wrong = guess_wrong;

    assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign pos_raw   = lfsr_step[2:0];
    assign pos_next  = (pos_raw == mole_pos_q) ? pos_raw + 3'd1 : pos_raw;

`ifdef MOLE_SPEEDUP_EN
    localparam logic [8:0] W_LIM = 9'(WINDOW_MIN + WINDOW_STEP);
    logic [7:0] window_q, window_d;

    always_comb begin
        window_d = window_q;
        if ((state_q == IDLE || state_q == OVER) && start) begin
            window_d = 8'(WINDOW_INIT);
        end else if (state_q == SHOW && guess_correct) begin
            window_d = ({1'b0, window_q} >= W_LIM) ? window_q - 8'(WINDOW_STEP) : 8'(WINDOW_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) window_q <= 8'(WINDOW_INIT);
        else     window_q <= window_d;
    end

    assign window_cur = window_q;
`else
    localparam int UNUSED_CFG = WINDOW_MIN + WINDOW_STEP;
    assign window_cur = 8'(WINDOW_INIT);
`endif

    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        gap_cnt_d     = gap_cnt_q;
        show_cnt_d    = show_cnt_q;
        mole_pos_d    = mole_pos_q;
        mole_change_d = 1'b0;
        round_cnt_d   = round_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    lfsr_d      = LFSR_SEED;
                    round_cnt_d = 6'd0;
                    miss_cnt_d  = 6'd0;
                    gap_cnt_d   = GAP_LD;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_cnt_q <= 8'd1) begin
                        if (round_cnt_q == ROUNDS_C) begin
                            state_d = OVER;
                        end else begin
                            lfsr_d        = lfsr_step;
                            mole_pos_d    = pos_next;
                            mole_change_d = 1'b1;
                            round_cnt_d   = (round_cnt_q == 6'd63) ? 6'd63 : round_cnt_q + 6'd1;
                            show_cnt_d    = window_cur;
                            state_d       = SHOW;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q - 8'd1;
                    end
                end
            end
            SHOW: begin
                // A hit wins over a timeout landing in the same cycle.
                if (guess_correct) begin
                    gap_cnt_d = GAP_LD;
                    state_d   = GAP;
                end else if (tick) begin
                    if (show_cnt_q <= 8'd1) begin
                        miss_cnt_d = (miss_cnt_q == 6'd63) ? 6'd63 : miss_cnt_q + 6'd1;
                        gap_cnt_d  = GAP_LD;
                        state_d    = GAP;
                    end else begin
                        show_cnt_d = show_cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        mole_visible_d = (state_d == SHOW);
        game_over_d    = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            lfsr_q         <= LFSR_SEED;
            gap_cnt_q      <= 8'd0;
            show_cnt_q     <= 8'd0;
            mole_pos_q     <= 3'd0;
            mole_change_q  <= 1'b0;
            mole_visible_q <= 1'b0;
            round_cnt_q    <= 6'd0;
            miss_cnt_q     <= 6'd0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            gap_cnt_q      <= gap_cnt_d;
            show_cnt_q     <= show_cnt_d;
            mole_pos_q     <= mole_pos_d;
            mole_change_q  <= mole_change_d;
            mole_visible_q <= mole_visible_d;
            round_cnt_q    <= round_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            game_over_q    <= game_over_d;
        end
    end

    assign mole_pos     = mole_pos_q;
    assign mole_change  = mole_change_q;
    assign mole_visible = mole_visible_q;
    assign round_cnt    = round_cnt_q;
    assign miss_cnt     = miss_cnt_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_mole_controller.sv
// tb/tb_mole_controller.sv - vector table, directed corner cases and randomized full games for mole_controller.
module tb_mole_controller;

    localparam logic [7:0] SEED     = 8'hA5;
    localparam int         WIN_INIT = 40;
    localparam int         WIN_MIN  = 10;
    localparam int         WIN_STEP = 2;
    localparam int         GAP      = 5;
    localparam int         ROUNDS   = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0, tick = 1'b0, start = 1'b0, guess_correct = 1'b0, guess_wrong = 1'b0;
    logic [2:0] mole_pos;
    logic       mole_change, mole_visible, game_over;
    logic [5:0] round_cnt, miss_cnt;

    mole_controller #(
        .LFSR_SEED(SEED), .WINDOW_INIT(WIN_INIT), .WINDOW_MIN(WIN_MIN),
        .WINDOW_STEP(WIN_STEP), .GAP_TICKS(GAP), .ROUNDS(ROUNDS)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .guess_correct(guess_correct), .guess_wrong(guess_wrong),
        .mole_pos(mole_pos), .mole_change(mole_change), .mole_visible(mole_visible),
        .round_cnt(round_cnt), .miss_cnt(miss_cnt), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: game-level bookkeeping only.
    logic [7:0] m_lfsr = SEED;
    logic [2:0] m_pos  = 3'd0;
    int         m_round = 0, m_miss = 0, m_hits = 0;

    typedef struct {
        logic r, s, t, g, w;
        logic e_chg, e_vis, e_over;
        int   e_round, e_miss;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic t, input logic g, input logic w);
        rst = r; start = s; tick = t; guess_correct = g; guess_wrong = w;
        @(posedge clk);
        #1;
        rst = 0; start = 0; tick = 0; guess_correct = 0; guess_wrong = 0;
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic model_new_mole();
        logic [2:0] p;
        m_lfsr = lfsr_next(m_lfsr);
        p = m_lfsr[2:0];
        if (p == m_pos) p = p + 3'd1;
        m_pos = p;
        m_round = (m_round >= 63) ? 63 : m_round + 1;
    endtask

    function automatic int cur_window();
        int w;
`ifdef MOLE_SPEEDUP_EN
        w = WIN_INIT - WIN_STEP * m_hits;
        if (w < WIN_MIN) w = WIN_MIN;
`else
        w = WIN_INIT;
`endif
        return w;
    endfunction

    function automatic vec_t mk(input logic r, s, t, g, w, c, v, o, input int rc, mc);
        vec_t x;
        x.r = r; x.s = s; x.t = t; x.g = g; x.w = w;
        x.e_chg = c; x.e_vis = v; x.e_over = o; x.e_round = rc; x.e_miss = mc;
        return x;
    endfunction

    // Blank interval with random idle cycles; stray hits and wrong guesses must be ignored.
    task automatic gap_phase();
        logic [2:0] old;
        old = m_pos;
        for (int k = 1; k <= GAP; k++) begin
            int idle = $urandom_range(0, 2);
            for (int i = 0; i < idle; i++) begin
                cyc(0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                chk("gap_idle_change", mole_change, 0);
            end
            cyc(0, 0, 1, 0, 1'($urandom_range(0, 1)));
            if (k < GAP) begin
                chk("gap_early_change", mole_change, 0);
            end else if (m_round == ROUNDS) begin
                chk("over_flag", game_over, 1);
                chk("over_visible", mole_visible, 0);
                chk("over_change", mole_change, 0);
            end else begin
                model_new_mole();
                chk("mole_change", mole_change, 1);
                chk("mole_visible", mole_visible, 1);
                chk("mole_pos", mole_pos, m_pos);
                chk("mole_pos_differs", 32'(mole_pos != old), 1);
                chk("round_cnt", round_cnt, m_round);
                cyc(0, 0, 0, 0, 0);
                chk("change_one_cycle", mole_change, 0);
            end
        end
    endtask

    task automatic show_miss();
        int w;
        w = cur_window();
        for (int k = 1; k <= w; k++) begin
            cyc(0, 0, 1, 0, 1'($urandom_range(0, 1)));
            if (k == w - 1) chk("visible_before_timeout", mole_visible, 1);
        end
        m_miss++;
        chk("timeout_visible", mole_visible, 0);
        chk("miss_cnt", miss_cnt, m_miss);
    endtask

    task automatic show_hit(input int h, input logic t_with_hit);
        for (int k = 0; k < h; k++) cyc(0, 0, 1, 0, 1'($urandom_range(0, 1)));
        chk("visible_before_hit", mole_visible, 1);
        cyc(0, 0, t_with_hit, 1, 0);
        m_hits++;
        chk("hit_visible", mole_visible, 0);
        chk("hit_miss_cnt", miss_cnt, m_miss);
    endtask

    initial begin
        // Vector table: rst s t g w | chg vis over round miss
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < GAP - 1; i++) tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < GAP - 1; i++) tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 2, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].t, tbl[i].g, tbl[i].w);
            if (tbl[i].r) begin m_lfsr = SEED; m_pos = 3'd0; end
            if (tbl[i].e_chg) model_new_mole();
            chk($sformatf("tbl%0d_change", i), mole_change, tbl[i].e_chg);
            chk($sformatf("tbl%0d_visible", i), mole_visible, tbl[i].e_vis);
            chk($sformatf("tbl%0d_over", i), game_over, tbl[i].e_over);
            chk($sformatf("tbl%0d_round", i), round_cnt, tbl[i].e_round);
            chk($sformatf("tbl%0d_miss", i), miss_cnt, tbl[i].e_miss);
            chk($sformatf("tbl%0d_pos", i), mole_pos, m_pos);
        end

        // Full game: reset, miss, then hit coinciding with the expiring tick, then random play.
        cyc(1, 0, 0, 0, 0);
        m_lfsr = SEED; m_pos = 3'd0; m_round = 0; m_miss = 0; m_hits = 0;
        cyc(0, 1, 0, 0, 0);
        chk("start_round_clear", round_cnt, 0);
        gap_phase();
        show_miss();
        gap_phase();
        show_hit(cur_window() - 1, 1'b1);
        for (int r = 3; r <= ROUNDS; r++) begin
            gap_phase();
            if ($urandom_range(0, 2) == 0) show_miss();
            else show_hit($urandom_range(0, cur_window() - 1), 1'($urandom_range(0, 1)));
        end
        gap_phase();
        chk("final_round_cnt", round_cnt, ROUNDS);
        chk("final_miss_cnt", miss_cnt, m_miss);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 0);
        chk("over_holds", game_over, 1);
        chk("over_no_change", mole_change, 0);

        // Restart from OVER: LFSR reloads, but the no-repeat rule sees the last mole.
        cyc(0, 1, 0, 0, 0);
        m_lfsr = SEED; m_round = 0; m_miss = 0; m_hits = 0;
        chk("restart_over", game_over, 0);
        chk("restart_round", round_cnt, 0);
        chk("restart_miss", miss_cnt, 0);
        gap_phase();
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1);

        // Reset mid-SHOW beats every other input.
        cyc(1, 1, 1, 1, 1);
        chk("rst_pos", mole_pos, 0);
        chk("rst_change", mole_change, 0);
        chk("rst_visible", mole_visible, 0);
        chk("rst_round", round_cnt, 0);
        chk("rst_miss", miss_cnt, 0);
        chk("rst_over", game_over, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 0, 1);
            chk("idle_visible", mole_visible, 0);
            chk("idle_change", mole_change, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_controller.md
MOLE_CONTROLLER -- requirements
Module: mole_controller

Interface
REQ-001 Parameter LFSR_SEED, default 8'hA5: nonzero LFSR value loaded on reset and on start.
REQ-002 Parameter WINDOW_INIT, default 40: mole visible window, in ticks, for the first mole.
REQ-003 Parameter WINDOW_MIN, default 10: lower bound of the visible window, in ticks.
REQ-004 Parameter WINDOW_STEP, default 2: window decrement, in ticks, per hit.
REQ-005 Parameter GAP_TICKS, default 5: blank interval, in ticks, between moles.
REQ-006 Parameter ROUNDS, default 32: number of moles per game.
REQ-007 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 tick  input  1  one-cycle time-base enable pulse, nominally 1 kHz.
REQ-010 start  input  1  one-cycle pulse that begins a game.
REQ-011 guess_correct  input  1  hit indication from the score evaluator.
REQ-012 guess_wrong  input  1  level from the score evaluator; informational only.
REQ-013 mole_pos  output  3  current mole hole index, 0-7.
REQ-014 mole_change  output  1  one-cycle pulse, asserted in the same cycle mole_pos takes a new value.
REQ-015 mole_visible  output  1  high while in state SHOW.
REQ-016 round_cnt  output  6  number of moles presented so far in the current game.
REQ-017 miss_cnt  output  6  number of moles that timed out.
REQ-018 game_over  output  1  high in state OVER.

Function
REQ-019 FSM states SHALL be IDLE, SHOW, GAP and OVER; outputs are registered.
REQ-020 IDLE: start -> load the LFSR, load the window with WINDOW_INIT, clear round_cnt and miss_cnt, then go to GAP with the gap counter = GAP_TICKS.
REQ-021 GAP: decrement the gap counter on tick; when it reaches 0 with round_cnt == ROUNDS -> OVER; otherwise -> SHOW.
REQ-022 On GAP->SHOW: step the 8-bit Fibonacci LFSR once (taps 8,6,5,4); mole_pos <= lfsr[2:0]; pulse mole_change for 1 cycle; round_cnt += 1; load the show counter with the current window.
REQ-023 If the new lfsr[2:0] equals the previous mole_pos, mole_pos SHALL be (lfsr[2:0]+1) mod 8, so consecutive moles never repeat a position.
REQ-024 SHOW: guess_correct=1 -> hit; go to GAP with the gap counter = GAP_TICKS.
REQ-025 SHOW: on tick, decrement the show counter; when it reaches 0 -> miss; miss_cnt += 1; go to GAP.
REQ-026 Simultaneous guess_correct and expiring tick in one cycle: the hit SHALL take priority and miss_cnt is unchanged.
REQ-027 guess_wrong SHALL NOT end SHOW; the mole stays until a hit or a timeout.
REQ-028 guess_correct outside SHOW SHALL be ignored.
REQ-029 start outside IDLE and OVER SHALL be ignored; start in OVER behaves as in IDLE.
REQ-030 miss_cnt and round_cnt SHALL saturate at 63.
REQ-031 The window is unsigned; a decrement SHALL never go below WINDOW_MIN (clamp, no wrap).
REQ-032 Latency: mole_change is asserted in the cycle after the tick that empties the gap counter.

Reset
REQ-033 rst SHALL force state IDLE within 1 cycle from any state, including mid-SHOW.
REQ-034 Reset values: mole_pos=0, mole_change=0, mole_visible=0, round_cnt=0, miss_cnt=0, game_over=0, lfsr=LFSR_SEED, window=WINDOW_INIT.
REQ-035 rst SHALL take priority over start, tick and guess_correct in the same cycle.

Configuration
REQ-036 Macro MOLE_SPEEDUP_EN defined: each hit SHALL reduce the window by WINDOW_STEP, clamped at WINDOW_MIN.
REQ-037 Macro MOLE_SPEEDUP_EN undefined: the window SHALL stay at WINDOW_INIT for the whole game, with no speedup logic synthesized.

Verification
REQ-038 rst, then start, then 5 ticks -> exactly one mole_change pulse; mole_visible=1; round_cnt=1; mole_pos=LFSR-derived value.
REQ-039 In SHOW, no guess for 40 ticks -> miss_cnt=1; state GAP; next mole_pos differs from the previous one.
REQ-040 With MOLE_SPEEDUP_EN, hit 16 moles -> window 40,38,...,12,10,10 (clamped at 10).
REQ-041 guess_correct and the 40th tick in the same cycle -> miss_cnt unchanged; treated as a hit.
REQ-042 Play 32 rounds -> game_over=1 after the final gap; start then restarts with round_cnt=0.
REQ-043 rst asserted mid-SHOW -> next cycle IDLE with all outputs at reset values; guess_wrong held high has no effect.
